// File: rtl/serial_mem_responder.sv
// Byte-serial memory responder: assembles 16-bit PC/address/store values from core bytes
// and streams memory words back. Optional idle abort enabled by `define RESP_TIMEOUT_EN.
module serial_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_pc,
    input  logic       bus_mar,
    input  logic       bus_mdr,
    input  logic [7:0] core_out,
    input  logic       rd_req,
    output logic [7:0] in_bus,
    output logic       ard_data_ready,
    output logic       ard_receive_ready,
    output logic       err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("serial_mem_responder: DEPTH must be a power of two and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        RX_LO,
        ADDR_HELD,
        ST_LO,
        SEND
    } state_t;

    logic [15:0]   mem [DEPTH];

    state_t        state, state_nxt;
    logic          kind_pc, kind_pc_nxt;
    logic [7:0]    hi, hi_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [31:0]   sr, sr_nxt;
    logic [1:0]    left, left_nxt;
    logic          err_q, err_nxt;
    logic          wr_en;

    logic [1:0]    sel_cnt;
    logic          any_sel, multi_sel, accept;
    logic [AW-1:0] rx_addr, rd_addr, rd_addr_inc;
    logic [15:0]   mem_rd_a, mem_rd_b;

`ifdef RESP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt, cnt_nxt;
`endif

    function automatic logic [1:0] count_sel(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

    assign sel_cnt   = count_sel(bus_pc, bus_mar, bus_mdr);
    assign any_sel   = (sel_cnt != 2'd0);
    assign multi_sel = (sel_cnt > 2'd1);
    assign accept    = (state != SEND) && (sel_cnt == 2'd1);

    // Fetch completes from {hi, core_out} in the same cycle; reads in ADDR_HELD use the held address.
    assign rx_addr     = AW'({hi, core_out});
    assign rd_addr     = (state == ADDR_HELD) ? addr : rx_addr;
    assign rd_addr_inc = rd_addr + AW'(1);
    assign mem_rd_a    = mem[rd_addr];
    assign mem_rd_b    = mem[rd_addr_inc];

    always_comb begin
        state_nxt   = state;
        kind_pc_nxt = kind_pc;
        hi_nxt      = hi;
        addr_nxt    = addr;
        sr_nxt      = sr;
        left_nxt    = left;
        err_nxt     = 1'b0;
        wr_en       = 1'b0;
`ifdef RESP_TIMEOUT_EN
        cnt_nxt     = '0;
`endif

        if (multi_sel || (state == SEND && any_sel) || (rd_req && state != ADDR_HELD)) begin
            err_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus_mdr) begin
                        err_nxt = 1'b1;
                    end else begin
                        hi_nxt      = core_out;
                        kind_pc_nxt = bus_pc;
                        state_nxt   = RX_LO;
                    end
                end
            end
            RX_LO: begin
                if (accept) begin
                    if (bus_mdr) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else if (bus_pc == kind_pc) begin
                        if (kind_pc) begin
                            sr_nxt    = {mem_rd_a, mem_rd_b};
                            left_nxt  = 2'd3;
                            state_nxt = SEND;
                        end else begin
                            addr_nxt  = rx_addr;
                            state_nxt = ADDR_HELD;
                        end
                    end else begin
                        // Kind switched mid-value: flag it and treat this byte as a fresh high byte.
                        err_nxt     = 1'b1;
                        hi_nxt      = core_out;
                        kind_pc_nxt = bus_pc;
                    end
                end
            end
            ADDR_HELD: begin
                if (rd_req) begin
                    sr_nxt    = {mem_rd_a, 16'h0000};
                    left_nxt  = 2'd1;
                    state_nxt = SEND;
                    if (accept) err_nxt = 1'b1;
                end else if (accept) begin
                    hi_nxt = core_out;
                    if (bus_mdr) begin
                        state_nxt = ST_LO;
                    end else begin
                        kind_pc_nxt = bus_pc;
                        state_nxt   = RX_LO;
                    end
                end
            end
            ST_LO: begin
                if (accept) begin
                    if (bus_mdr) wr_en = 1'b1;
                    else         err_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SEND: begin
                sr_nxt   = {sr[23:0], 8'h00};
                left_nxt = left - 2'd1;
                if (left == 2'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

`ifdef RESP_TIMEOUT_EN
        if ((state == RX_LO || state == ADDR_HELD || state == ST_LO) && !accept
            && !(state == ADDR_HELD && rd_req)) begin
            if (cnt == CW'(TIMEOUT - 1)) begin
                err_nxt   = 1'b1;
                state_nxt = IDLE;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            kind_pc <= 1'b0;
            hi      <= 8'h00;
            addr    <= '0;
            sr      <= '0;
            left    <= '0;
            err_q   <= 1'b0;
`ifdef RESP_TIMEOUT_EN
            cnt     <= '0;
`endif
        end else begin
            state   <= state_nxt;
            kind_pc <= kind_pc_nxt;
            hi      <= hi_nxt;
            addr    <= addr_nxt;
            sr      <= sr_nxt;
            left    <= left_nxt;
            err_q   <= err_nxt;
`ifdef RESP_TIMEOUT_EN
            cnt     <= cnt_nxt;
`endif
        end
    end

    // Storage is never reset; writes only happen from ST_LO, which reset leaves immediately.
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= {hi, core_out};
    end

    assign ard_receive_ready = (state != SEND);
    assign ard_data_ready    = (state == SEND);
    assign in_bus            = (state == SEND) ? sr[31:24] : 8'h00;
    assign err               = err_q;

endmodule

// File: tb/tb_serial_mem_responder.sv
// Directed bench for serial_mem_responder: store, load, wrapping fetch, error pulses,
// reset mid-transfer and idle behaviour (timeout expectations follow RESP_TIMEOUT_EN).
module tb_serial_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       bus_pc, bus_mar, bus_mdr;
    logic [7:0] core_out;
    logic       rd_req;
    logic [7:0] in_bus;
    logic       ard_data_ready, ard_receive_ready, err;

    int n_checks = 0;
    int n_errors = 0;

    serial_mem_responder dut (
        .clk              (clk),
        .rst              (rst),
        .bus_pc           (bus_pc),
        .bus_mar          (bus_mar),
        .bus_mdr          (bus_mdr),
        .core_out         (core_out),
        .rd_req           (rd_req),
        .in_bus           (in_bus),
        .ard_data_ready   (ard_data_ready),
        .ard_receive_ready(ard_receive_ready),
        .err              (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic p, input logic m, input logic d, input logic [7:0] b);
        bus_pc = p; bus_mar = m; bus_mdr = d; core_out = b;
        tick();
        bus_pc = 1'b0; bus_mar = 1'b0; bus_mdr = 1'b0; core_out = 8'h00;
    endtask

    task automatic pulse_rd();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    // Checks {data_ready, receive_ready, in_bus} for one streamed byte, then advances.
    task automatic expect_send(input string tag, input logic [7:0] b);
        check(tag, {22'd0, ard_data_ready, ard_receive_ready, in_bus}, {22'd0, 1'b1, 1'b0, b});
        tick();
    endtask

    task automatic expect_idle(input string tag);
        check(tag, {22'd0, ard_data_ready, ard_receive_ready, in_bus}, {22'd0, 1'b0, 1'b1, 8'h00});
    endtask

    task automatic store_word(input logic [15:0] a, input logic [15:0] d);
        put(0, 1, 0, a[15:8]);
        put(0, 1, 0, a[7:0]);
        put(0, 0, 1, d[15:8]);
        put(0, 0, 1, d[7:0]);
    endtask

    task automatic load_word(input string tag, input logic [15:0] a, input logic [15:0] d);
        put(0, 1, 0, a[15:8]);
        put(0, 1, 0, a[7:0]);
        pulse_rd();
        expect_send({tag, "_hi"}, d[15:8]);
        expect_send({tag, "_lo"}, d[7:0]);
        expect_idle({tag, "_end"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_seen;
        int err_first;

        rst = 1'b1; bus_pc = 1'b0; bus_mar = 1'b0; bus_mdr = 1'b0;
        core_out = 8'h00; rd_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {23'd0, ard_data_ready, in_bus, err}, 32'd0);
        check("reset_rx_ready", {31'd0, ard_receive_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Store 16'hABCD at address 16
        put(0, 1, 0, 8'h00);
        put(0, 1, 0, 8'h10);
        put(0, 0, 1, 8'hAB);
        check("store_hi_err", {31'd0, err}, 32'd0);
        put(0, 0, 1, 8'hCD);
        check("store_lo_err", {31'd0, err}, 32'd0);
        expect_idle("store_end");

        load_word("load16", 16'h0010, 16'hABCD);

        // Fetch across the top of memory
        store_word(16'h00FF, 16'h1234);
        store_word(16'h0000, 16'h5678);
        put(1, 0, 0, 8'h00);
        put(1, 0, 0, 8'hFF);
        expect_send("fetch_b0", 8'h12);
        expect_send("fetch_b1", 8'h34);
        expect_send("fetch_b2", 8'h56);
        expect_send("fetch_b3", 8'h78);
        expect_idle("fetch_end");

        // Store byte in IDLE is a one-cycle error
        put(0, 0, 1, 8'h55);
        check("mdr_idle_err", {31'd0, err}, 32'd1);
        tick();
        check("mdr_idle_err_clear", {31'd0, err}, 32'd0);

        // Two selects at once in ADDR_HELD: error, held address survives
        put(0, 1, 0, 8'h00);
        put(0, 1, 0, 8'h10);
        put(1, 1, 0, 8'h22);
        check("multi_sel_err", {31'd0, err}, 32'd1);
        pulse_rd();
        check("rd_after_multi_err", {31'd0, err}, 32'd0);
        expect_send("multi_keep_hi", 8'hAB);
        expect_send("multi_keep_lo", 8'hCD);

        // Kind change in RX_LO restarts as an address
        put(1, 0, 0, 8'h00);
        put(0, 1, 0, 8'h00);
        check("kind_change_err", {31'd0, err}, 32'd1);
        put(0, 1, 0, 8'h10);
        check("kind_change_next_err", {31'd0, err}, 32'd0);
        pulse_rd();
        expect_send("kind_change_hi", 8'hAB);
        expect_send("kind_change_lo", 8'hCD);

        // rd_req in IDLE
        pulse_rd();
        check("rd_idle_err", {31'd0, err}, 32'd1);
        expect_idle("rd_idle_state");

        // Byte offered during SEND is flagged and ignored
        put(0, 1, 0, 8'h00);
        put(0, 1, 0, 8'h10);
        pulse_rd();
        check("send_b0", {24'd0, in_bus}, 32'h0000_00AB);
        put(0, 1, 0, 8'h33);
        check("send_busy_b1", {24'd0, in_bus}, 32'h0000_00CD);
        check("send_busy_err", {31'd0, err}, 32'd1);
        tick();
        expect_idle("send_busy_end");

        // Reset between store bytes abandons the write
        put(0, 1, 0, 8'h00);
        put(0, 1, 0, 8'h10);
        put(0, 0, 1, 8'h99);
        rst = 1'b1;
        #2;
        expect_idle("reset_mid_async");
        tick();
        rst = 1'b0;
        tick();
        put(0, 0, 1, 8'h77);
        check("reset_mid_idle_err", {31'd0, err}, 32'd1);
        load_word("reset_mid_mem", 16'h0010, 16'hABCD);

        // Read back a freshly written word
        store_word(16'h0020, 16'hBEEF);
        load_word("raw", 16'h0020, 16'hBEEF);

        // Long silence after a single address byte
        err_seen  = 0;
        err_first = 0;
        put(0, 1, 0, 8'h00);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (err === 1'b1) begin
                err_seen++;
                if (err_first == 0) err_first = i;
            end
        end
`ifdef RESP_TIMEOUT_EN
        check("timeout_pulses", err_seen, 1);
        check("timeout_cycle", err_first, 16);
        expect_idle("timeout_state");
`else
        check("no_timeout_pulses", err_seen, 0);
        put(0, 1, 0, 8'h10);
        pulse_rd();
        expect_send("no_timeout_hi", 8'hAB);
        expect_send("no_timeout_lo", 8'hCD);
        expect_idle("no_timeout_end");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_mem_responder.md
SERIAL_MEM_RESPONDER -- requirements
Module: serial_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 16-bit memory words; address taken modulo DEPTH (power of two).
REQ-002 SHALL have parameter TIMEOUT, default 16: idle cycles before an incomplete transfer aborts (used only with RESP_TIMEOUT_EN).
REQ-003 SHALL use one clock, clk; reset rst is asynchronous and active-high.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 bus_pc  input  1  core drives PC byte on core_out.
REQ-007 bus_mar  input  1  core drives address byte on core_out.
REQ-008 bus_mdr  input  1  core drives store-data byte on core_out.
REQ-009 core_out  input  8  byte from core.
REQ-010 rd_req  input  1  one-cycle pulse: read word at held address.
REQ-011 in_bus  output  8  byte to core.
REQ-012 ard_data_ready  output  1  in_bus valid this cycle.
REQ-013 ard_receive_ready  output  1  responder accepts a core_out byte this cycle.
REQ-014 err  output  1  one-cycle protocol-error pulse.

Function
REQ-015 A byte SHALL be accepted only in a cycle with ard_receive_ready=1 and exactly one of bus_pc/bus_mar/bus_mdr high; all 16-bit values travel high byte first.
REQ-016 States SHALL be IDLE, RX_LO, ADDR_HELD, ST_LO, SEND; ard_receive_ready=1 in every state except SEND.
REQ-017 IDLE: accepted bus_pc or bus_mar byte -> latch high byte and kind, go RX_LO; bus_mdr byte in IDLE -> err pulse, stay IDLE.
REQ-018 RX_LO: byte of same kind completes 16-bit value; bus_pc -> SEND with 4 bytes queued: mem[pc] hi, mem[pc] lo, mem[pc+1] hi, mem[pc+1] lo (pc+1 wraps modulo DEPTH); bus_mar -> ADDR_HELD.
REQ-019 RX_LO: byte of different kind SHALL pulse err and restart as first byte of the new kind (bus_mdr -> err, IDLE).
REQ-020 ADDR_HELD: rd_req -> SEND with mem[addr] hi, lo queued; bus_mdr byte -> latch high data, go ST_LO; bus_mar byte -> RX_LO with new address; bus_pc byte -> RX_LO as fetch.
REQ-021 ST_LO: bus_mdr byte SHALL write {hi,lo} to mem[addr] on that clock edge and return IDLE; any other kind -> err, IDLE.
REQ-022 rd_req outside ADDR_HELD SHALL pulse err and be otherwise ignored; rd_req coincident with an accepted byte in ADDR_HELD: rd_req wins, byte ignored, err pulses.
REQ-023 SEND: ard_data_ready=1 for consecutive cycles, one byte per cycle, no backpressure; first byte appears cycle after the completing byte or rd_req; IDLE after last byte.
REQ-024 A bus_* assertion during SEND, or more than one bus_* high in any state, SHALL pulse err and be ignored.
REQ-025 Read of a word written the previous cycle SHALL return the new value.
REQ-026 in_bus SHALL be 8'h00 whenever ard_data_ready=0.

Reset
REQ-027 While rst=1: state IDLE, ard_data_ready=0, ard_receive_ready=1 after deassert, in_bus=0, err=0, latches cleared; memory contents not reset.
REQ-028 Reset mid-transfer SHALL abandon it; no partial write occurs.

Configuration
REQ-029 Macro RESP_TIMEOUT_EN defined: in RX_LO, ADDR_HELD or ST_LO, TIMEOUT consecutive cycles with no accepted byte/rd_req SHALL pulse err and return IDLE; counter clears on every accepted event.
REQ-030 RESP_TIMEOUT_EN undefined: those states wait indefinitely; no counter logic present.

Verification
REQ-031 Store: bus_mar 8'h00,8'h10; bus_mdr 8'hAB,8'hCD -> mem[16]=16'hABCD, err=0.
REQ-032 Load: bus_mar 8'h00,8'h10, rd_req -> next two cycles in_bus 8'hAB,8'hCD with ard_data_ready=1.
REQ-033 Fetch wrap: mem[255]=16'h1234, mem[0]=16'h5678; bus_pc 8'h00,8'hFF -> in_bus 12,34,56,78 on four consecutive cycles, ard_receive_ready=0 throughout.
REQ-034 Errors: bus_mdr byte in IDLE -> err one cycle; bus_pc and bus_mar both high -> err, state unchanged.
REQ-035 Reset after store high byte only -> memory unchanged, state IDLE.
REQ-036 With RESP_TIMEOUT_EN, TIMEOUT=16: single bus_mar byte then silence -> err pulses on 16th idle cycle, state IDLE; without macro -> no err.
